mem_issue_queue: RTL and testbench
==================================

Name: mem_issue_queue

Overview:
- In-order circular queue between dispatch/rename and mem_unit; holds loads and stores in program order.
- Captures source operands from the CDB while entries wait.
- Presents the oldest entry to mem_unit once its operands are ready, with the effective address precomputed.
- Strict in-order issue, so memory ordering needs no disambiguation logic.

Parameters:
- DEPTH, 8: number of entries; power of two, minimum 2.
- ROB_IDX_W, 5: width of ROB index and operand tags.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset; one clock domain
- enq_valid  in  1  dispatch offers a memory op
- enq_ready  out  1  queue can accept (count < DEPTH)
- enq_is_store  in  1  1 = store, 0 = load
- enq_pc  in  32  instruction PC
- enq_inst  in  32  instruction word
- enq_funct3  in  3  size/sign field
- enq_imm  in  32  sign-extended offset
- enq_rob_idx  in  ROB_IDX_W  destination ROB slot
- enq_rd_addr  in  5  architectural rd
- enq_rs1_rdy / enq_rs2_rdy  in  1 each  operand already valid
- enq_rs1_tag / enq_rs2_tag  in  ROB_IDX_W each  producer ROB index when not ready
- enq_rs1_data / enq_rs2_data  in  32 each  operand value when ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_rob_idx  in  ROB_IDX_W  producing ROB slot
- cdb_data  in  32  broadcast value
- flush  in  1  pipeline flush
- iss_valid  out  1  head entry ready for mem_unit
- iss_ready  in  1  mem_unit accepts (its stall is low)
- iss_is_store, iss_pc, iss_inst, iss_funct3, iss_rob_idx, iss_rd_addr  out  head fields
- iss_addr  out  32  rs1 + imm, full byte address, not aligned
- iss_store_data  out  32  rs2 value, unshifted
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst==0 at a clk edge): head=tail=0, all entry valid bits 0, count=0. Outputs after reset: iss_valid=0, enq_ready=1, all iss_* payloads 0.
- Pointers carry one extra wrap bit. Empty when head==tail. Full when indices are equal and wrap bits differ. Pointers wrap modulo DEPTH.
- Enqueue on enq_valid && enq_ready: write the tail entry, tail++. enq_ready is 0 when full, even if a dequeue happens the same cycle (no full-bypass).
- Same-cycle wakeup at enqueue: if a not-ready source tag equals cdb_rob_idx with cdb_valid=1, the entry is written ready with cdb_data.
- Wakeup of stored entries: every cycle, each valid entry with a not-ready source whose tag matches cdb_rob_idx (cdb_valid=1) captures cdb_data and sets ready. rs1 and rs2 are matched independently; both may match the same broadcast.
- Issue eligibility: iss_valid = head valid && rs1 ready && (load || rs2 ready). Purely combinational from registered state.
- Latency: an op enqueued with ready operands at edge N shows iss_valid in cycle N+1. An operand arriving on the CDB at edge N gives iss_valid in N+1.
- Dequeue on iss_valid && iss_ready: head++, head valid cleared. iss_* payloads stay stable while iss_valid=1 and iss_ready=0.
- Simultaneous enqueue and dequeue: both occur; count unchanged.
- No issue past a blocked head: younger ready entries wait.
- flush=1 at an edge: all valids cleared, head=tail=0, count=0. Flush has priority over enqueue, dequeue and wakeup in that cycle. iss_valid=0 in the following cycle.
- Reset asserted mid-operation has the same effect as flush plus payload clear.

Optional Feature:
- Macro MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN.
- Defined: adds output iss_misaligned (1 bit). It is asserted with iss_valid when iss_addr violates the funct3 size: half-word with addr[0]=1, or word with addr[1:0]!=0. The entry still issues; the ROB handles the exception.
- Undefined: port absent; no check logic.

Decomposition:
- Shared package rv32i_types gets mem_iq_entry_t (valid, is_store, pc, inst, funct3, imm, rob_idx, rd_addr, rs1/rs2 rdy/tag/data).
- Also add constants for the funct3 size codes: MEM_B=000, MEM_H=001, MEM_W=010, MEM_BU=100, MEM_HU=101.
- One natural sub-module: mem_iq_operand. It is the per-source tag-compare and capture cell, instantiated 2×DEPTH.

Test Plan:
- Reset then load enqueue (rs1_rdy=1, rs1_data=0x1000, imm=0x8) -> next cycle iss_valid=1, iss_addr=0x1008; iss_ready=1 -> count 1→0.
- Store enqueued with rs2 not ready, tag=3; cdb_valid, rob_idx=3, data=0xDEADBEEF two cycles later -> iss_valid rises the cycle after, iss_store_data=0xDEADBEEF.
- Fill 8 entries, iss_ready=0 -> enq_ready=0, count=8. Then simultaneous enqueue and dequeue -> enqueue refused until count=7. Run past 16 ops to exercise wrap.
- Head load blocked on tag 5, younger load ready -> iss_valid=0 until tag 5 broadcasts; issue order stays oldest first.
- flush with 4 entries plus a simultaneous enqueue -> next cycle count=0, iss_valid=0, enqueued op discarded.
- With MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN: word load at addr 0x1002 -> iss_misaligned=1; byte load at 0x1003 -> iss_misaligned=0.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// rv32i_types : shared RV32I types; memory-issue-queue entry and funct3 codes
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  localparam int MEM_IQ_TAG_W = 5;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef struct packed {
    logic                    valid;
    logic                    is_store;
    logic [31:0]             pc;
    logic [31:0]             inst;
    logic [2:0]              funct3;
    logic [31:0]             imm;
    logic [MEM_IQ_TAG_W-1:0] rob_idx;
    logic [4:0]              rd_addr;
    logic                    rs1_rdy;
    logic [MEM_IQ_TAG_W-1:0] rs1_tag;
    logic [31:0]             rs1_data;
    logic                    rs2_rdy;
    logic [MEM_IQ_TAG_W-1:0] rs2_tag;
    logic [31:0]             rs2_data;
  } mem_iq_entry_t;

  // Natural-alignment violation for the access size encoded in funct3
  function automatic logic mem_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (funct3)
      MEM_B, MEM_BU: r = 1'b0;
      MEM_H, MEM_HU: r = addr_lo[0];
      MEM_W:         r = (addr_lo != 2'b00);
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_issue_queue_if.sv
`default_nettype none
// ============================================================================
// mem_issue_queue_if : dispatch, CDB, flush and mem_unit issue signals
// Optional macro     : MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN adds iss_misaligned
// Revision           : 1.0 - initial release
// ============================================================================
interface mem_issue_queue_if #(
  parameter int ROB_IDX_W = 5
);
  logic                 enq_valid;
  logic                 enq_ready;
  logic                 enq_is_store;
  logic [31:0]          enq_pc;
  logic [31:0]          enq_inst;
  logic [2:0]           enq_funct3;
  logic [31:0]          enq_imm;
  logic [ROB_IDX_W-1:0] enq_rob_idx;
  logic [4:0]           enq_rd_addr;
  logic                 enq_rs1_rdy;
  logic                 enq_rs2_rdy;
  logic [ROB_IDX_W-1:0] enq_rs1_tag;
  logic [ROB_IDX_W-1:0] enq_rs2_tag;
  logic [31:0]          enq_rs1_data;
  logic [31:0]          enq_rs2_data;

  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [31:0]          cdb_data;
  logic                 flush;

  logic                 iss_valid;
  logic                 iss_ready;
  logic                 iss_is_store;
  logic [31:0]          iss_pc;
  logic [31:0]          iss_inst;
  logic [2:0]           iss_funct3;
  logic [ROB_IDX_W-1:0] iss_rob_idx;
  logic [4:0]           iss_rd_addr;
  logic [31:0]          iss_addr;
  logic [31:0]          iss_store_data;
`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
  logic                 iss_misaligned;
`endif

  modport master (
`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
    input  iss_misaligned,
`endif
    output enq_valid, enq_is_store, enq_pc, enq_inst, enq_funct3, enq_imm,
           enq_rob_idx, enq_rd_addr, enq_rs1_rdy, enq_rs2_rdy, enq_rs1_tag,
           enq_rs2_tag, enq_rs1_data, enq_rs2_data,
           cdb_valid, cdb_rob_idx, cdb_data, flush, iss_ready,
    input  enq_ready, iss_valid, iss_is_store, iss_pc, iss_inst, iss_funct3,
           iss_rob_idx, iss_rd_addr, iss_addr, iss_store_data
  );

  modport slave (
`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
    output iss_misaligned,
`endif
    input  enq_valid, enq_is_store, enq_pc, enq_inst, enq_funct3, enq_imm,
           enq_rob_idx, enq_rd_addr, enq_rs1_rdy, enq_rs2_rdy, enq_rs1_tag,
           enq_rs2_tag, enq_rs1_data, enq_rs2_data,
           cdb_valid, cdb_rob_idx, cdb_data, flush, iss_ready,
    output enq_ready, iss_valid, iss_is_store, iss_pc, iss_inst, iss_funct3,
           iss_rob_idx, iss_rd_addr, iss_addr, iss_store_data
  );

endinterface
`default_nettype wire

// File: rtl/mem_iq_operand.sv
`default_nettype none
// ============================================================================
// mem_iq_operand : per-source tag compare and CDB capture for one queue slot
// Revision       : 1.0 - initial release
// ============================================================================
module mem_iq_operand
  import rv32i_types::*;
(
  input  logic                    valid,
  input  logic                    cur_rdy,
  input  logic [MEM_IQ_TAG_W-1:0] cur_tag,
  input  logic [31:0]             cur_data,
  input  logic                    wr_en,
  input  logic                    wr_rdy,
  input  logic [MEM_IQ_TAG_W-1:0] wr_tag,
  input  logic [31:0]             wr_data,
  input  logic                    cdb_valid,
  input  logic [MEM_IQ_TAG_W-1:0] cdb_tag,
  input  logic [31:0]             cdb_data,
  output logic                    nxt_rdy,
  output logic [MEM_IQ_TAG_W-1:0] nxt_tag,
  output logic [31:0]             nxt_data
);

  logic                    w_live;
  logic                    w_src_rdy;
  logic [MEM_IQ_TAG_W-1:0] w_src_tag;
  logic [31:0]             w_src_data;
  logic                    w_hit;

  // A slot being written this cycle compares the incoming tag, so a broadcast
  // coinciding with dispatch is not lost.
  always_comb begin
    w_live     = wr_en | valid;
    w_src_rdy  = wr_en ? wr_rdy  : cur_rdy;
    w_src_tag  = wr_en ? wr_tag  : cur_tag;
    w_src_data = wr_en ? wr_data : cur_data;
    w_hit      = w_live && !w_src_rdy && cdb_valid && (w_src_tag == cdb_tag);
    nxt_rdy    = w_src_rdy | w_hit;
    nxt_tag    = w_src_tag;
    nxt_data   = w_hit ? cdb_data : w_src_data;
  end

endmodule
`default_nettype wire

// File: rtl/mem_issue_queue.sv
`default_nettype none
// ============================================================================
// mem_issue_queue : in-order load/store issue queue with CDB operand capture
// Optional macro  : MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN (iss_misaligned output)
// Revision        : 1.0 - initial release
// ============================================================================
module mem_issue_queue
  import rv32i_types::*;
#(
  parameter int DEPTH     = 8,
  parameter int ROB_IDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_issue_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  mem_iq_entry_t           r_ent [DEPTH];
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;

  logic [IDX_W-1:0]        w_head_idx;
  logic [IDX_W-1:0]        w_tail_idx;
  logic                    w_full;
  logic                    w_enq;
  logic                    w_deq;
  logic                    w_iss_valid;
  logic [31:0]             w_addr;
  mem_iq_entry_t           w_head;
  logic [DEPTH-1:0]        w_wr;
  logic [DEPTH-1:0]        w_rs1_rdy;
  logic [DEPTH-1:0]        w_rs2_rdy;
  logic [MEM_IQ_TAG_W-1:0] w_rs1_tag  [DEPTH];
  logic [MEM_IQ_TAG_W-1:0] w_rs2_tag  [DEPTH];
  logic [31:0]             w_rs1_data [DEPTH];
  logic [31:0]             w_rs2_data [DEPTH];

  assign w_head_idx  = r_head[IDX_W-1:0];
  assign w_tail_idx  = r_tail[IDX_W-1:0];
  assign w_full      = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_head      = r_ent[w_head_idx];
  assign w_iss_valid = w_head.valid && w_head.rs1_rdy && (!w_head.is_store || w_head.rs2_rdy);
  assign w_addr      = w_head.rs1_data + w_head.imm;
  // Acceptance depends only on occupancy; a same-cycle dequeue does not free a slot early
  assign w_enq       = bus.enq_valid && !w_full;
  assign w_deq       = w_iss_valid && bus.iss_ready;

  assign count              = r_tail - r_head;
  assign bus.enq_ready      = !w_full;
  assign bus.iss_valid      = w_iss_valid;
  assign bus.iss_is_store   = w_head.is_store;
  assign bus.iss_pc         = w_head.pc;
  assign bus.iss_inst       = w_head.inst;
  assign bus.iss_funct3     = w_head.funct3;
  assign bus.iss_rob_idx    = ROB_IDX_W'(w_head.rob_idx);
  assign bus.iss_rd_addr    = w_head.rd_addr;
  assign bus.iss_addr       = w_addr;
  assign bus.iss_store_data = w_head.rs2_data;

`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
  assign bus.iss_misaligned = w_iss_valid && mem_misaligned(w_head.funct3, w_addr[1:0]);
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_wr[i] = w_enq && (w_tail_idx == IDX_W'(i));

    mem_iq_operand u_rs1 (
      .valid     (r_ent[i].valid),
      .cur_rdy   (r_ent[i].rs1_rdy),
      .cur_tag   (r_ent[i].rs1_tag),
      .cur_data  (r_ent[i].rs1_data),
      .wr_en     (w_wr[i]),
      .wr_rdy    (bus.enq_rs1_rdy),
      .wr_tag    (MEM_IQ_TAG_W'(bus.enq_rs1_tag)),
      .wr_data   (bus.enq_rs1_data),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (MEM_IQ_TAG_W'(bus.cdb_rob_idx)),
      .cdb_data  (bus.cdb_data),
      .nxt_rdy   (w_rs1_rdy[i]),
      .nxt_tag   (w_rs1_tag[i]),
      .nxt_data  (w_rs1_data[i])
    );

    mem_iq_operand u_rs2 (
      .valid     (r_ent[i].valid),
      .cur_rdy   (r_ent[i].rs2_rdy),
      .cur_tag   (r_ent[i].rs2_tag),
      .cur_data  (r_ent[i].rs2_data),
      .wr_en     (w_wr[i]),
      .wr_rdy    (bus.enq_rs2_rdy),
      .wr_tag    (MEM_IQ_TAG_W'(bus.enq_rs2_tag)),
      .wr_data   (bus.enq_rs2_data),
      .cdb_valid (bus.cdb_valid),
      .cdb_tag   (MEM_IQ_TAG_W'(bus.cdb_rob_idx)),
      .cdb_data  (bus.cdb_data),
      .nxt_rdy   (w_rs2_rdy[i]),
      .nxt_tag   (w_rs2_tag[i]),
      .nxt_data  (w_rs2_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].rs1_rdy  <= w_rs1_rdy[i];
        r_ent[i].rs1_tag  <= w_rs1_tag[i];
        r_ent[i].rs1_data <= w_rs1_data[i];
        r_ent[i].rs2_rdy  <= w_rs2_rdy[i];
        r_ent[i].rs2_tag  <= w_rs2_tag[i];
        r_ent[i].rs2_data <= w_rs2_data[i];
        if (w_wr[i]) begin
          r_ent[i].valid    <= 1'b1;
          r_ent[i].is_store <= bus.enq_is_store;
          r_ent[i].pc       <= bus.enq_pc;
          r_ent[i].inst     <= bus.enq_inst;
          r_ent[i].funct3   <= bus.enq_funct3;
          r_ent[i].imm      <= bus.enq_imm;
          r_ent[i].rob_idx  <= MEM_IQ_TAG_W'(bus.enq_rob_idx);
          r_ent[i].rd_addr  <= bus.enq_rd_addr;
        end else if (w_deq && (w_head_idx == IDX_W'(i))) begin
          r_ent[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_issue_queue.sv
`default_nettype none
// Testbench for mem_issue_queue: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_mem_issue_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;
  localparam int RW    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count;
  int         checks = 0;
  int         errors = 0;
  int unsigned pc_ctr = 32'h100;

  mem_issue_queue_if #(.ROB_IDX_W(RW)) bus ();

  mem_issue_queue #(.DEPTH(DEPTH), .ROB_IDX_W(RW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [4:0]  rob;
    logic [4:0]  rd;
    bit          r1;
    logic [4:0]  t1;
    logic [31:0] d1;
    bit          r2;
    logic [4:0]  t2;
    logic [31:0] d2;
  } op_t;

  op_t mq[$];

  function automatic bit m_valid();
    return (mq.size() > 0) && mq[0].r1 && (!mq[0].st || mq[0].r2);
  endfunction

  function automatic bit m_misaligned();
    logic [31:0] a;
    if (!m_valid()) return 1'b0;
    a = mq[0].d1 + mq[0].imm;
    if (mq[0].f3 == MEM_H || mq[0].f3 == MEM_HU) return (a % 2) != 0;
    if (mq[0].f3 == MEM_W) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Advance the model across one clock edge using the inputs present at that edge
  function automatic void model_edge();
    op_t n;
    bit  deq;
    bit  enq;
    if (!rst || bus.flush) begin
      mq.delete();
      return;
    end
    deq = m_valid() && bus.iss_ready;
    enq = bus.enq_valid && (mq.size() < DEPTH);
    n.st = bus.enq_is_store; n.pc = bus.enq_pc; n.inst = bus.enq_inst;
    n.f3 = bus.enq_funct3; n.imm = bus.enq_imm; n.rob = bus.enq_rob_idx;
    n.rd = bus.enq_rd_addr;
    n.r1 = bus.enq_rs1_rdy; n.t1 = bus.enq_rs1_tag; n.d1 = bus.enq_rs1_data;
    n.r2 = bus.enq_rs2_rdy; n.t2 = bus.enq_rs2_tag; n.d2 = bus.enq_rs2_data;
    if (bus.cdb_valid && !n.r1 && n.t1 == bus.cdb_rob_idx) begin n.r1 = 1; n.d1 = bus.cdb_data; end
    if (bus.cdb_valid && !n.r2 && n.t2 == bus.cdb_rob_idx) begin n.r2 = 1; n.d2 = bus.cdb_data; end
    if (deq) void'(mq.pop_front());
    foreach (mq[i]) begin
      if (bus.cdb_valid && !mq[i].r1 && mq[i].t1 == bus.cdb_rob_idx) begin mq[i].r1 = 1; mq[i].d1 = bus.cdb_data; end
      if (bus.cdb_valid && !mq[i].r2 && mq[i].t2 == bus.cdb_rob_idx) begin mq[i].r2 = 1; mq[i].d2 = bus.cdb_data; end
    end
    if (enq) mq.push_back(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.enq_valid = 0; bus.enq_is_store = 0; bus.enq_pc = '0; bus.enq_inst = '0;
    bus.enq_funct3 = '0; bus.enq_imm = '0; bus.enq_rob_idx = '0; bus.enq_rd_addr = '0;
    bus.enq_rs1_rdy = 0; bus.enq_rs2_rdy = 0; bus.enq_rs1_tag = '0; bus.enq_rs2_tag = '0;
    bus.enq_rs1_data = '0; bus.enq_rs2_data = '0;
    bus.cdb_valid = 0; bus.cdb_rob_idx = '0; bus.cdb_data = '0; bus.flush = 0;
  endtask

  task automatic set_enq(input bit st, input bit r1, input logic [4:0] t1, input logic [31:0] d1,
                         input bit r2, input logic [4:0] t2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [2:0] f3, input logic [4:0] rob);
    bus.enq_valid = 1; bus.enq_is_store = st; bus.enq_pc = pc_ctr; bus.enq_inst = $urandom;
    bus.enq_funct3 = f3; bus.enq_imm = imm; bus.enq_rob_idx = rob; bus.enq_rd_addr = 5'($urandom);
    bus.enq_rs1_rdy = r1; bus.enq_rs1_tag = t1; bus.enq_rs1_data = d1;
    bus.enq_rs2_rdy = r2; bus.enq_rs2_tag = t2; bus.enq_rs2_data = d2;
    pc_ctr += 4;
  endtask

  task automatic test_reset();
    idle();
    bus.iss_ready = 0;
    rst = 0;
    tick(); tick();
    rst = 1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid: got %b want 0", bus.iss_valid); end
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b want 1", bus.enq_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if ({bus.iss_addr, bus.iss_store_data, bus.iss_pc, bus.iss_rob_idx} !== '0) begin
      errors++; $display("FAIL reset_payload: got addr=%h sdata=%h pc=%h rob=%0d want all 0",
                         bus.iss_addr, bus.iss_store_data, bus.iss_pc, bus.iss_rob_idx);
    end
  endtask

  task automatic test_load_issue();
    set_enq(0, 1, 0, 32'h1000, 1, 0, 0, 32'h8, MEM_W, 5'd1);
    tick(); idle();
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL load_iss_valid: got %b want 1", bus.iss_valid); end
    checks++; if (bus.iss_addr !== 32'h1008) begin errors++; $display("FAIL load_addr: got %h want 00001008", bus.iss_addr); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL load_count_before: got %0d want 1", count); end
    bus.iss_ready = 1;
    tick();
    bus.iss_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL load_count_after: got %0d want 0", count); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL load_drained: got %b want 0", bus.iss_valid); end
  endtask

  task automatic test_store_wakeup();
    set_enq(1, 1, 0, 32'h2000, 0, 5'd3, 0, 32'h4, MEM_W, 5'd2);
    tick(); idle();
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL store_wait1: got %b want 0", bus.iss_valid); end
    tick();
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL store_wait2: got %b want 0", bus.iss_valid); end
    bus.cdb_valid = 1; bus.cdb_rob_idx = 5'd3; bus.cdb_data = 32'hDEADBEEF;
    tick(); idle();
    checks++; if (bus.iss_valid !== 1'b1) begin errors++; $display("FAIL store_woken: got %b want 1", bus.iss_valid); end
    checks++; if (bus.iss_store_data !== 32'hDEADBEEF) begin errors++; $display("FAIL store_data: got %h want deadbeef", bus.iss_store_data); end
    checks++; if (bus.iss_addr !== 32'h2004 || bus.iss_is_store !== 1'b1) begin
      errors++; $display("FAIL store_addr: got %h st=%b want 00002004 st=1", bus.iss_addr, bus.iss_is_store);
    end
    bus.iss_ready = 1; tick(); bus.iss_ready = 0;
  endtask

  task automatic test_full_and_wrap();
    logic [4:0] exp_rob;
    bus.iss_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(0, 1, 0, 32'h100 * i, 1, 0, 0, 0, MEM_B, 5'(i));
      tick();
    end
    idle();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", count); end
    checks++; if (bus.enq_ready !== 1'b0) begin errors++; $display("FAIL full_enq_ready: got %b want 0", bus.enq_ready); end
    set_enq(0, 1, 0, 32'h800, 1, 0, 0, 0, MEM_B, 5'd8);
    bus.iss_ready = 1;
    tick();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_no_bypass: got %0d want 7", count); end
    tick();
    idle();
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_enq_deq: got %0d want 7", count); end
    exp_rob = 5'd2;
    for (int c = 0; c < 20 && count != 0; c++) begin
      checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob_idx !== exp_rob) begin
        errors++; $display("FAIL drain_order: got valid=%b rob=%0d want valid=1 rob=%0d", bus.iss_valid, bus.iss_rob_idx, exp_rob);
      end
      exp_rob++;
      tick();
    end
    checks++; if (count !== 4'd0 || exp_rob !== 5'd9) begin
      errors++; $display("FAIL drain_done: got count=%0d next_rob=%0d want 0 and 9", count, exp_rob);
    end
    bus.iss_ready = 0;
  endtask

  task automatic test_blocked_head();
    set_enq(0, 0, 5'd5, 0, 1, 0, 0, 32'h10, MEM_W, 5'd10);
    tick();
    set_enq(0, 1, 0, 32'h4000, 1, 0, 0, 0, MEM_W, 5'd11);
    tick(); idle();
    bus.iss_ready = 1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.iss_valid !== 1'b0 || count !== 4'd2) begin
        errors++; $display("FAIL blocked_head: got valid=%b count=%0d want 0 and 2", bus.iss_valid, count);
      end
      tick();
    end
    bus.cdb_valid = 1; bus.cdb_rob_idx = 5'd5; bus.cdb_data = 32'h3000;
    tick(); bus.cdb_valid = 0;
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob_idx !== 5'd10 || bus.iss_addr !== 32'h3010) begin
      errors++; $display("FAIL blocked_release: got valid=%b rob=%0d addr=%h want 1 10 00003010", bus.iss_valid, bus.iss_rob_idx, bus.iss_addr);
    end
    tick();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_rob_idx !== 5'd11) begin
      errors++; $display("FAIL blocked_second: got valid=%b rob=%0d want 1 11", bus.iss_valid, bus.iss_rob_idx);
    end
    tick();
    bus.iss_ready = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL blocked_drain: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    bus.iss_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_enq(0, 1, 0, 32'h40 * i, 1, 0, 0, 0, MEM_W, 5'(20 + i));
      tick();
    end
    set_enq(1, 1, 0, 32'h50, 1, 0, 0, 0, MEM_W, 5'd24);
    bus.flush = 1;
    tick(); idle();
    checks++; if (count !== 4'd0 || bus.iss_valid !== 1'b0 || bus.enq_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got count=%0d valid=%b enq_ready=%b want 0 0 1", count, bus.iss_valid, bus.enq_ready);
    end
    tick();
    checks++; if (count !== 4'd0 || bus.iss_valid !== 1'b0) begin
      errors++; $display("FAIL flush_discard: got count=%0d valid=%b want 0 0", count, bus.iss_valid);
    end
  endtask

`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
  task automatic test_misalign();
    bus.iss_ready = 0;
    set_enq(0, 1, 0, 32'h1000, 1, 0, 0, 32'h2, MEM_W, 5'd1);
    tick(); idle();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_misaligned !== 1'b1) begin
      errors++; $display("FAIL misalign_word: got valid=%b mis=%b want 1 1", bus.iss_valid, bus.iss_misaligned);
    end
    bus.iss_ready = 1; tick(); bus.iss_ready = 0;
    set_enq(0, 1, 0, 32'h1000, 1, 0, 0, 32'h3, MEM_B, 5'd2);
    tick(); idle();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_misaligned !== 1'b0) begin
      errors++; $display("FAIL misalign_byte: got valid=%b mis=%b want 1 0", bus.iss_valid, bus.iss_misaligned);
    end
    bus.iss_ready = 1; tick(); bus.iss_ready = 0;
  endtask
`endif

  task automatic test_random();
    logic [2:0] f3s [5];
    logic [135:0] exp_p;
    logic [135:0] got_p;
    f3s[0] = MEM_B; f3s[1] = MEM_H; f3s[2] = MEM_W; f3s[3] = MEM_BU; f3s[4] = MEM_HU;
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        set_enq($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                $urandom, f3s[$urandom_range(0, 4)], 5'($urandom));
      bus.cdb_valid   = $urandom_range(0, 1);
      bus.cdb_rob_idx = 5'($urandom_range(0, 7));
      bus.cdb_data    = $urandom;
      bus.iss_ready   = ($urandom_range(0, 9) < 4);
      bus.flush       = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, count, mq.size()); end
      checks++; if (bus.iss_valid !== m_valid() || bus.enq_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL rand_ctrl c=%0d: got valid=%b enq_ready=%b want %b %b", c, bus.iss_valid, bus.enq_ready, m_valid(), mq.size() < DEPTH);
      end
      if (m_valid()) begin
        exp_p = {mq[0].st, mq[0].pc, mq[0].inst, mq[0].f3, mq[0].rob, mq[0].rd, mq[0].d1 + mq[0].imm, mq[0].d2};
        got_p = {bus.iss_is_store, bus.iss_pc, bus.iss_inst, bus.iss_funct3, bus.iss_rob_idx,
                 bus.iss_rd_addr, bus.iss_addr, bus.iss_store_data};
        checks++; if (got_p !== exp_p) begin errors++; $display("FAIL rand_payload c=%0d: got %h want %h", c, got_p, exp_p); end
      end
`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
      checks++; if (bus.iss_misaligned !== m_misaligned()) begin
        errors++; $display("FAIL rand_misaligned c=%0d: got %b want %b", c, bus.iss_misaligned, m_misaligned());
      end
`endif
    end
    idle();
    bus.iss_ready = 0;
  endtask

  initial begin
    test_reset();
    test_load_issue();
    test_store_wakeup();
    test_full_and_wrap();
    test_blocked_head();
    test_flush();
`ifdef MEM_ISSUE_QUEUE_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
